// File: rtl/enthdr_ctrl_tgt_top.sv
// enthdr_ctrl_tgt_top: I3C SDR controller looped back to a target for ENTHDR0.
// Optional macro ENTHDR_PARITY_CHECK_EN: target also checks the CCC T-bit.
module enthdr_ctrl_tgt_top #(
  parameter int          SCL_HALF = 4,
  parameter logic [11:0] CFG_BASE = 12'd1000
) (
  input  logic        i_sdr_clk,
  input  logic        i_sdr_rst,
  input  logic        i_controller_en,
  input  logic        i_i3c_i2c_sel,
  input  logic        i_ccc_en_dis_hj,
  input  logic [7:0]  i_regf_config,
  input  logic        i_data_config_mux_sel,
  input  logic [11:0] i_regf_wr_address_config,
  input  logic        i_regf_wr_en_config,
  input  logic        i_regf_rd_en_config,
  inout  wire         sda,
  output logic        scl,
  output logic        o_sdr_rx_valid,
  output logic        o_ctrl_done,
  input  logic        i_tgt_engine_en,
  output wire         o_tgt_sdahnd_sda,
  output logic        o_tgt_pp_od_sdahand,
  output logic        o_tgt_engine_done
);

  localparam int CW = (SCL_HALF > 2) ? $clog2(SCL_HALF) : 1;
  localparam logic [8:0] CCC_WORD = {8'h20, ~^8'h20};

  typedef enum logic [3:0] {
    C_IDLE, C_START, C_BCAST, C_ACK, C_CCC,
    C_PRE, C_EXIT, C_STOP, C_DONE
  } c_st_t;

  typedef enum logic [2:0] {
    T_IDLE, T_ADDR, T_ACK, T_CCC, T_HDR
  } t_st_t;

  logic [7:0] desc [8];
  logic [11:0] off;
  logic in_win;

  c_st_t c_st;
  logic [CW-1:0] cnt;
  logic hi, oe, sdo, en_q, skip;
  logic [3:0] bitn;
  logic [8:0] shreg;

  t_st_t t_st;
  logic [7:0] tsh;
  logic [3:0] tcnt;
  logic [1:0] hcnt;
  logic tack, scl_q, sda_q;

  logic bus, tick, last, toc, frame_ok, en_rise;
  logic t_start, t_stop, t_rise, t_fall, t_sfall, ccc_ok;
  logic unused;

  assign off    = i_regf_wr_address_config - CFG_BASE;
  assign in_win = off < 12'd8;

  always_ff @(posedge i_sdr_clk or posedge i_sdr_rst) begin
    if (i_sdr_rst) begin
      for (int i = 0; i < 8; i++) desc[i] <= '0;
    end else if (i_data_config_mux_sel && i_regf_wr_en_config
                 && in_win) begin
      desc[off[2:0]] <= i_regf_config;
    end
  end

  assign toc      = desc[3][7];
  assign frame_ok = (desc[3][4:2] == 3'd6) && !desc[3][5];
  assign en_rise  = i_controller_en && !en_q && i_i3c_i2c_sel
                    && !i_data_config_mux_sel;
  assign tick     = cnt == CW'(SCL_HALF - 1);
  assign last     = (c_st == C_BCAST) ? (bitn == 4'd7)
                                      : (bitn == 4'd8);

  // Released SDA reads high through the external pull-up.
  assign bus = oe ? sdo : ~tack;
  assign sda = oe ? sdo : (tack ? 1'b0 : 1'bz);
  assign o_tgt_sdahnd_sda    = tack ? 1'b0 : 1'bz;
  assign o_tgt_pp_od_sdahand = 1'b0;

  always_ff @(posedge i_sdr_clk or posedge i_sdr_rst) begin
    if (i_sdr_rst) begin
      c_st  <= C_IDLE;
      cnt   <= '0;
      hi    <= 1'b0;
      bitn  <= '0;
      shreg <= '0;
      oe    <= 1'b0;
      sdo   <= 1'b1;
      scl   <= 1'b1;
      en_q  <= 1'b0;
      skip  <= 1'b0;
      o_sdr_rx_valid <= 1'b0;
      o_ctrl_done    <= 1'b0;
    end else begin
      en_q <= i_controller_en;
      o_sdr_rx_valid <= 1'b0;
      o_ctrl_done    <= 1'b0;
      cnt <= tick ? '0 : cnt + CW'(1);
      unique case (c_st)
        C_IDLE: begin
          cnt <= '0;
          hi  <= 1'b0;
          if (en_rise) begin
            if (frame_ok) begin
              c_st <= C_START;
              oe   <= 1'b1;
              sdo  <= 1'b0;
            end else begin
              c_st <= C_DONE;
              skip <= 1'b1;
            end
          end
        end
        C_START: if (tick) begin
          c_st  <= C_BCAST;
          scl   <= 1'b0;
          shreg <= {8'hFC, 1'b0};
          sdo   <= 1'b1;
          bitn  <= '0;
        end
        C_BCAST, C_CCC: if (tick) begin
          if (!hi) begin
            scl <= 1'b1;
            hi  <= 1'b1;
          end else begin
            scl <= 1'b0;
            hi  <= 1'b0;
            if (!last) begin
              sdo   <= shreg[7];
              shreg <= {shreg[7:0], 1'b0};
              bitn  <= bitn + 4'd1;
            end else begin
              oe   <= 1'b0;
              c_st <= (c_st == C_BCAST) ? C_ACK : C_PRE;
            end
          end
        end
        C_ACK: if (tick) begin
          if (!hi) begin
            scl <= 1'b1;
            hi  <= 1'b1;
          end else begin
            scl <= 1'b0;
            hi  <= 1'b0;
            oe  <= 1'b1;
            if (!bus) begin
              o_sdr_rx_valid <= 1'b1;
              c_st  <= C_CCC;
              shreg <= CCC_WORD;
              sdo   <= CCC_WORD[8];
              bitn  <= '0;
            end else begin
              c_st <= C_STOP;
              sdo  <= 1'b0;
            end
          end
        end
        C_PRE: if (tick) begin
          oe   <= 1'b1;
          sdo  <= 1'b0;
          bitn <= '0;
          c_st <= toc ? C_EXIT : C_STOP;
        end
        // Seven SCL-low levels 0,1,0,1,0,1,0 give four SDA falls.
        C_EXIT: if (tick) begin
          if (bitn == 4'd6) begin
            c_st <= C_STOP;
          end else begin
            sdo  <= ~sdo;
            bitn <= bitn + 4'd1;
          end
        end
        C_STOP: if (tick) begin
          if (!hi) begin
            scl <= 1'b1;
            hi  <= 1'b1;
          end else begin
            hi   <= 1'b0;
            oe   <= 1'b0;
            c_st <= C_DONE;
            o_ctrl_done <= 1'b1;
          end
        end
        C_DONE: begin
          c_st <= C_IDLE;
          o_ctrl_done <= skip;
          skip <= 1'b0;
        end
        default: c_st <= C_IDLE;
      endcase
    end
  end

  assign t_start = scl && scl_q && sda_q && !bus;
  assign t_stop  = scl && scl_q && !sda_q && bus;
  assign t_rise  = scl && !scl_q;
  assign t_fall  = !scl && scl_q;
  assign t_sfall = !scl && !scl_q && sda_q && !bus;

`ifdef ENTHDR_PARITY_CHECK_EN
  assign ccc_ok = (tsh == 8'h20) && (bus == ~^tsh);
`else
  assign ccc_ok = tsh == 8'h20;
`endif

  always_ff @(posedge i_sdr_clk or posedge i_sdr_rst) begin
    if (i_sdr_rst) begin
      t_st  <= T_IDLE;
      tsh   <= '0;
      tcnt  <= '0;
      hcnt  <= '0;
      tack  <= 1'b0;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      o_tgt_engine_done <= 1'b0;
    end else begin
      scl_q <= scl;
      sda_q <= bus;
      o_tgt_engine_done <= 1'b0;
      if (!i_tgt_engine_en) begin
        t_st <= T_IDLE;
        tack <= 1'b0;
      end else if (t_start) begin
        t_st <= T_ADDR;
        tcnt <= '0;
        tack <= 1'b0;
      end else begin
        unique case (t_st)
          T_IDLE: ;
          T_ADDR: begin
            if (t_rise) begin
              tsh  <= {tsh[6:0], bus};
              tcnt <= tcnt + 4'd1;
            end else if (t_fall && tcnt == 4'd8) begin
              tack <= tsh == 8'hFC;
              t_st <= (tsh == 8'hFC) ? T_ACK : T_IDLE;
            end
          end
          T_ACK: if (t_fall) begin
            tack <= 1'b0;
            tcnt <= '0;
            t_st <= T_CCC;
          end
          T_CCC: if (t_rise) begin
            if (tcnt == 4'd8) begin
              o_tgt_engine_done <= ccc_ok;
              hcnt <= '0;
              t_st <= ccc_ok ? T_HDR : T_IDLE;
            end else begin
              tsh  <= {tsh[6:0], bus};
              tcnt <= tcnt + 4'd1;
            end
          end
          T_HDR: begin
            if (t_stop) begin
              t_st <= T_IDLE;
            end else if (t_sfall) begin
              hcnt <= hcnt + 2'd1;
              if (hcnt == 2'd3) t_st <= T_IDLE;
            end
          end
          default: t_st <= T_IDLE;
        endcase
      end
    end
  end

  assign unused = ^{i_ccc_en_dis_hj, i_regf_rd_en_config,
                    desc[0], desc[1], desc[2], desc[3][6],
                    desc[3][1:0], desc[4], desc[5], desc[6],
                    desc[7]};

endmodule

// File: tb/tb_enthdr_ctrl_tgt_top.sv
// tb_enthdr_ctrl_tgt_top: directed frames against a cycle-level bus model.
// Model builds expected SCL/SDA/pulse waveforms from bit sequences.
module tb_enthdr_ctrl_tgt_top;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, sel = 1'b1, hj = 1'b0, mux = 1'b0;
  logic wr = 1'b0, rd = 1'b0, ten = 1'b0;
  logic [7:0]  wdata = '0;
  logic [11:0] waddr = '0;
  wire sda, tsda;
  logic scl, rxv, cdone, ppod, tdone;

  pullup (sda);
  pullup (tsda);

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rx_i, td_i;

  // {scl, sda, tsda, rxv, cdone, tdone, ppod}
  typedef logic [6:0] ev_t;
  ev_t q[$];

  always #5 clk = ~clk;

  enthdr_ctrl_tgt_top #(.SCL_HALF(H), .CFG_BASE(12'd1000)) dut (
    .i_sdr_clk(clk),
    .i_sdr_rst(rst),
    .i_controller_en(en),
    .i_i3c_i2c_sel(sel),
    .i_ccc_en_dis_hj(hj),
    .i_regf_config(wdata),
    .i_data_config_mux_sel(mux),
    .i_regf_wr_address_config(waddr),
    .i_regf_wr_en_config(wr),
    .i_regf_rd_en_config(rd),
    .sda(sda),
    .scl(scl),
    .o_sdr_rx_valid(rxv),
    .o_ctrl_done(cdone),
    .i_tgt_engine_en(ten),
    .o_tgt_sdahnd_sda(tsda),
    .o_tgt_pp_od_sdahand(ppod),
    .o_tgt_engine_done(tdone)
  );

  always @(negedge clk) begin
    ev_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {scl, sda, tsda, rxv, cdone, tdone, ppod};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL wave k=%0d scl/sda/tsda/rxv/cdone/tdone/ppod got %b required %b",
                 cyc, g, e);
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit before summary");
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic seg(input logic s, input logic d, input int n);
    for (int i = 0; i < n; i++) q.push_back({s, d, 1'b1, 4'b0000});
  endtask

  task automatic setbit(input int idx, input int b, input logic v);
    ev_t t;
    t = q[idx];
    t[b] = v;
    q[idx] = t;
  endtask

  task automatic stop_tail();
    int d;
    seg(1'b0, 1'b0, H);
    seg(1'b1, 1'b0, H);
    d = q.size();
    seg(1'b1, 1'b1, 1);
    setbit(d, 2, 1'b1);
    seg(1'b1, 1'b1, 6);
  endtask

  // Expected bus for one enable edge: tgt=target enabled,
  // toc=exit pattern wanted, ok=descriptor qualifies a frame.
  task automatic build(input bit tgt, input bit toc, input bit ok);
    logic [7:0] bc;
    logic [8:0] w;
    int a0, th, b0;
    logic ackv;
    bc = 8'hFC;
    w = {8'h20, 1'b0};
    rx_i = -1;
    td_i = -1;
    b0 = q.size();
    if (!ok) begin
      seg(1'b1, 1'b1, 2);
      setbit(b0 + 1, 2, 1'b1);
      seg(1'b1, 1'b1, 4);
      return;
    end
    seg(1'b1, 1'b0, H);
    for (int i = 7; i >= 0; i--) begin
      seg(1'b0, bc[i], H);
      seg(1'b1, bc[i], H);
    end
    a0 = q.size();
    ackv = !tgt;
    seg(1'b0, ackv, H);
    setbit(a0, 5, 1'b1);
    seg(1'b1, ackv, H);
    if (ackv) begin
      stop_tail();
      return;
    end
    rx_i = q.size();
    th = 0;
    for (int i = 8; i >= 0; i--) begin
      seg(1'b0, w[i], H);
      if (i == 0) th = q.size();
      seg(1'b1, w[i], H);
    end
    td_i = th + 1;
    for (int i = a0 + 1; i <= a0 + 2 * H; i++) setbit(i, 4, 1'b0);
    setbit(rx_i, 3, 1'b1);
    setbit(td_i, 1, 1'b1);
    seg(1'b0, 1'b1, H);
    if (toc)
      for (int j = 0; j < 7; j++) seg(1'b0, (j % 2) == 1, H);
    stop_tail();
    rx_i -= b0;
    td_i -= b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic frame(input bit tgt, input bit toc, input bit ok);
    @(negedge clk);
    #1;
    build(tgt, toc, ok);
    en = 1'b1;
    drain();
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_cfg(input logic [11:0] a, input logic [7:0] d,
                        input logic m);
    @(negedge clk);
    #1;
    mux = m;
    waddr = a;
    wdata = d;
    wr = 1'b1;
    @(negedge clk);
    #1;
    wr = 1'b0;
    mux = 1'b0;
  endtask

  initial begin
    logic [7:0] img [8];
    img = '{8'h00, 8'h00, 8'h00, 8'h98, 8'h00, 8'h8A, 8'h5A, 8'hFF};
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({scl, sda, tsda, rxv, cdone, tdone, ppod}),
        int'(7'b1110000));
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", int'({scl, sda, tsda, rxv, cdone, tdone, ppod}),
        int'(7'b1110000));

    for (int i = 0; i < 8; i++) wr_cfg(12'd1000 + 12'(i), img[i], 1'b1);
    wr_cfg(12'd1003, 8'h14, 1'b0);
    wr_cfg(12'd1011, 8'h14, 1'b1);
    wr_cfg(12'd999, 8'h14, 1'b1);

    // Full frame with exit pattern; also pin model positions.
    ten = 1'b1;
    @(negedge clk);
    #1;
    build(1'b1, 1'b1, 1'b1);
    chk("pin_frame_len", q.size(), 195);
    chk("pin_rxv_cycle", rx_i, 76);
    chk("pin_tdone_cycle", td_i, 145);
    en = 1'b1;
    drain();
    en = 1'b0;
    @(negedge clk);

    ten = 1'b0;
    frame(1'b0, 1'b1, 1'b1);

    // I2C select inhibits the start entirely.
    sel = 1'b0;
    @(negedge clk);
    #1;
    seg(1'b1, 1'b1, 8);
    en = 1'b1;
    drain();
    en = 1'b0;
    sel = 1'b1;
    @(negedge clk);

    ten = 1'b1;
    wr_cfg(12'd1003, 8'h14, 1'b1);
    frame(1'b1, 1'b1, 1'b0);

    wr_cfg(12'd1003, 8'h18, 1'b1);
    @(negedge clk);
    #1;
    build(1'b1, 1'b0, 1'b1);
    chk("pin_noexit_len", q.size(), 167);
    en = 1'b1;
    drain();
    en = 1'b0;
    @(negedge clk);
    frame(1'b1, 1'b0, 1'b1);

    // Reset lands in the CCC phase.
    wr_cfg(12'd1003, 8'h98, 1'b1);
    @(negedge clk);
    #1;
    build(1'b1, 1'b1, 1'b1);
    en = 1'b1;
    repeat (110) @(negedge clk);
    #1;
    q.delete();
    rst = 1'b1;
    en = 1'b0;
    #1;
    chk("midreset_outputs",
        int'({scl, sda, tsda, rxv, cdone, tdone, ppod}),
        int'(7'b1110000));
    @(negedge clk);
    #1 rst = 1'b0;
    frame(1'b1, 1'b1, 1'b0);
    wr_cfg(12'd1003, 8'h98, 1'b1);
    frame(1'b1, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
